// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetcher with credit-limited memory requests, in-order
// response queue and redirect handling that discards responses from stale requests.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redirect_al;
    logic [CW-1:0]         outst_q, outst_d, disc_q, disc_d, count_q, count_d;
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0] fifo_pc_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_d [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_ins_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_ins_d [DEPTH];
    logic                  grant, push, pop;

    assign redirect_al = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    // Queued entries plus in-flight requests never exceed DEPTH, so a response always has room.
    assign mem_req     = RST && !redirect_valid && (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W);
    assign mem_addr    = fetch_pc_q;
    assign instr_valid = count_q != '0;
    assign instr       = instr_valid ? fifo_ins_q[rd_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_q] : '0;

    always_comb begin
        grant      = mem_req && mem_gnt;
        push       = mem_rvalid && disc_q == '0;
        pop        = instr_valid && instr_ready;
        fetch_pc_d = grant ? fetch_pc_q + STEP : fetch_pc_q;
        resp_pc_d  = push ? resp_pc_q + STEP : resp_pc_q;
        outst_d    = outst_q + CW'(grant) - CW'(mem_rvalid);
        disc_d     = (mem_rvalid && !push) ? disc_q - CW'(1) : disc_q;
        wr_d       = push ? wr_q + AW'(1) : wr_q;
        rd_d       = pop ? rd_q + AW'(1) : rd_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        fifo_pc_d  = fifo_pc_q;
        fifo_ins_d = fifo_ins_q;
        if (push) begin
            fifo_pc_d[wr_q]  = resp_pc_q;
            fifo_ins_d[wr_q] = mem_rdata;
        end
        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = redirect_al;
            resp_pc_d  = redirect_al;
            disc_d     = outst_d;
            wr_d       = '0;
            rd_d       = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            disc_q     <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            fifo_pc_q  <= '{default: '0};
            fifo_ins_q <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            fifo_pc_q  <= fifo_pc_d;
            fifo_ins_q <= fifo_ins_d;
        end
    end
endmodule
